simple_conv_pool_core: RTL and testbench



---
 rtl/simple_conv_pool_core_pkg.sv | 33 +++
 rtl/simple_conv_pool_core_conv3x3_mac.sv | 18 +
 rtl/simple_conv_pool_core.sv | 160 ++++++++++++++++
 tb/tb_simple_conv_pool_core.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/simple_conv_pool_core_pkg.sv
// Shared types and constants for the 8x8 conv/pool engine.
// Kernel defaults, bus map and the top-level state encoding.
package simple_conv_pool_core_pkg;

   localparam int IMG_W     = 8;
   localparam int CONV_W    = 6;
   localparam int POOL_W    = 3;
   localparam int PIX_W     = 8;
   localparam int ACC_W     = 16;
   localparam int K_W       = 4;
   localparam int NPIX      = IMG_W * IMG_W;
   localparam int OUT_SHIFT = 4;

   localparam logic [7:0] BASE_IN  = 8'd1;
   localparam logic [7:0] BASE_OUT = 8'd65;

   localparam logic [9*K_W-1:0] KERNEL_DEF = {9{4'd1}};

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      COMPUTE,
      WRITE,
      DONE
   } state_t;

   function automatic logic [PIX_W-1:0] sat_out(input logic [ACC_W-1:0] v);
      logic [ACC_W-1:0] s;
      s = v >> OUT_SHIFT;
      return (s > 16'd255) ? 8'hff : s[PIX_W-1:0];
   endfunction

endpackage

// File: rtl/simple_conv_pool_core_conv3x3_mac.sv
// Combinational 3x3 multiply-accumulate.
// Element n of pix/wt is row-major, n=0 is the top-left tap.
module conv3x3_mac
   import simple_conv_pool_core_pkg::*;
(
   input  logic [9*PIX_W-1:0] pix,
   input  logic [9*K_W-1:0]   wt,
   output logic [ACC_W-1:0]   sum
);

   always_comb begin
      sum = '0;
      for (int n = 0; n < 9; n++) begin
         sum = sum + ACC_W'(pix[n*PIX_W +: PIX_W]) * ACC_W'(wt[n*K_W +: K_W]);
      end
   end

endmodule

// File: rtl/simple_conv_pool_core.sv
// Self-starting engine: load 8x8 image, 3x3 conv, 2x2 max-pool,
// write 3x3 result back. Bus outputs are registered.
module simple_conv_pool_core
   import simple_conv_pool_core_pkg::*;
#(
   parameter logic [9*K_W-1:0] KERNEL = KERNEL_DEF
)
(
   input  logic             clk,
   input  logic             rst,
   output logic             read,
   output logic [7:0]       addr,
   output logic [PIX_W-1:0] din,
   input  logic [PIX_W-1:0] dout,
   output logic             write
);

   state_t state, state_n;

   logic [6:0] cnt, cnt_n;
   logic [1:0] win, win_n;
   logic [1:0] pi, pi_n;
   logic [1:0] pj, pj_n;

   logic [ACC_W-1:0] mx, sum, mx_next;
   logic [PIX_W-1:0] img_buf [NPIX];
   logic [9*PIX_W-1:0] wpix;
   logic [2:0] r0, c0;
   logic [5:0] cap_idx;

   logic             read_n, write_n;
   logic [7:0]       addr_n;
   logic [PIX_W-1:0] din_n;

   // Window top-left: pool cell origin plus the sub-window offset.
   assign r0 = {pi, 1'b0} + {2'b0, win[1]};
   assign c0 = {pj, 1'b0} + {2'b0, win[0]};

   always_comb begin
      wpix = '0;
      for (int a = 0; a < 3; a++) begin
         for (int b = 0; b < 3; b++) begin
            wpix[(a*3+b)*PIX_W +: PIX_W] =
               img_buf[{r0 + 3'(a), c0 + 3'(b)}];
         end
      end
   end

   conv3x3_mac u_mac (
      .pix (wpix),
      .wt  (KERNEL),
      .sum (sum)
   );

   assign mx_next = (win == 2'd0) ? sum : ((sum > mx) ? sum : mx);
   assign cap_idx = 6'(cnt - 7'd1);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         cnt   <= '0;
         win   <= '0;
         pi    <= '0;
         pj    <= '0;
         mx    <= '0;
         read  <= 1'b0;
         write <= 1'b0;
         addr  <= '0;
         din   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         win   <= win_n;
         pi    <= pi_n;
         pj    <= pj_n;
         read  <= read_n;
         write <= write_n;
         addr  <= addr_n;
         din   <= din_n;
         if (state == COMPUTE) begin
            mx <= mx_next;
         end else if (state == WRITE) begin
            mx <= '0;
         end
      end
   end

   // Read data arrives one cycle after its strobe, so capture lags by one.
   always_ff @(posedge clk) begin
      if (state == LOAD && cnt != 7'd0) begin
         img_buf[cap_idx] <= dout;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      win_n   = win;
      pi_n    = pi;
      pj_n    = pj;
      unique case (state)
         IDLE: begin
            state_n = LOAD;
            cnt_n   = '0;
         end
         LOAD: begin
            if (cnt == 7'(NPIX)) begin
               state_n = COMPUTE;
               cnt_n   = '0;
               win_n   = '0;
               pi_n    = '0;
               pj_n    = '0;
            end else begin
               cnt_n = cnt + 7'd1;
            end
         end
         COMPUTE: begin
            win_n = win + 2'd1;
            if (win == 2'd3) begin
               state_n = WRITE;
            end
         end
         WRITE: begin
            if (pi == 2'(POOL_W-1) && pj == 2'(POOL_W-1)) begin
               state_n = DONE;
            end else begin
               state_n = COMPUTE;
               if (pj == 2'(POOL_W-1)) begin
                  pj_n = '0;
                  pi_n = pi + 2'd1;
               end else begin
                  pj_n = pj + 2'd1;
               end
            end
         end
         DONE: begin
            state_n = DONE;
         end
         default: state_n = IDLE;
      endcase
   end

   // Outputs are computed for the upcoming state and registered.
   always_comb begin
      read_n  = 1'b0;
      write_n = 1'b0;
      addr_n  = addr;
      din_n   = din;
      if (state_n == LOAD && cnt_n < 7'(NPIX)) begin
         read_n = 1'b1;
         addr_n = BASE_IN + 8'(cnt_n);
      end
      if (state_n == WRITE) begin
         write_n = 1'b1;
         addr_n  = BASE_OUT + 8'(pi) * 8'd3 + 8'(pj);
         din_n   = sat_out(mx_next);
      end
   end

endmodule

// File: tb/tb_simple_conv_pool_core.sv
// Bench: memory models, image reference model, cycle-level bus checks.
// Runs fixed and random images, plus a reset in the middle of LOAD.
module tb_simple_conv_pool_core;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       read, write, read15, write15;
   logic [7:0] addr, din, dout, addr15, din15, dout15;

   logic [7:0] mem   [256];
   logic [7:0] mem15 [256];
   int         img   [64];
   int         exp1  [9];
   int         exp15 [9];

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   bit active = 1'b0;
   int nreads, nwrites;

   always #5 clk = ~clk;

   simple_conv_pool_core u_dut (
      .clk   (clk),
      .rst   (rst),
      .read  (read),
      .addr  (addr),
      .din   (din),
      .dout  (dout),
      .write (write)
   );

   simple_conv_pool_core #(.KERNEL({9{4'd15}})) u_dut15 (
      .clk   (clk),
      .rst   (rst),
      .read  (read15),
      .addr  (addr15),
      .din   (din15),
      .dout  (dout15),
      .write (write15)
   );

   always @(posedge clk) begin
      if (read) dout <= mem[addr];
      if (write) mem[addr] <= din;
      if (read15) dout15 <= mem15[addr15];
      if (write15) mem15[addr15] <= din15;
   end

   task automatic check(input string name, input int act, input int want);
      tests++;
      if (act != want) begin
         fails++;
         $display("FAIL %s at cyc %0d: got %0d want %0d", name, cyc, act, want);
      end
   endtask

   function automatic int model(input int i, input int j, input int k);
      int best, s;
      best = 0;
      for (int di = 0; di < 2; di++) begin
         for (int dj = 0; dj < 2; dj++) begin
            s = 0;
            for (int a = 0; a < 3; a++)
               for (int b = 0; b < 3; b++)
                  s += k * img[(2*i+di+a)*8 + 2*j+dj+b];
            if (s > best) best = s;
         end
      end
      best = best / 16;
      return (best > 255) ? 255 : best;
   endfunction

   always @(negedge clk) begin
      if (active) begin
         bit exp_rd, exp_wr;
         exp_rd = (cyc >= 1 && cyc <= 64);
         exp_wr = (cyc >= 70 && cyc <= 110 && (cyc - 70) % 5 == 0);
         check("read", int'(read), int'(exp_rd));
         check("write", int'(write), int'(exp_wr));
         if (exp_rd) check("rd_addr", int'(addr), cyc);
         if (exp_wr) begin
            check("wr_addr", int'(addr), 65 + (cyc - 70) / 5);
            check("wr_din", int'(din), exp1[(cyc - 70) / 5]);
         end
         if (cyc >= 111) begin
            check("done_addr", int'(addr), 73);
            check("done_din", int'(din), exp1[8]);
         end
         if (read) nreads++;
         if (write) nwrites++;
      end
   end

   task automatic release_rst();
      @(posedge clk);
      #1 rst = 1'b1;
      cyc = 0;
      nreads = 0;
      nwrites = 0;
      active = 1'b1;
   endtask

   task automatic run(input bit abort);
      rst = 1'b0;
      active = 1'b0;
      for (int a = 0; a < 256; a++) begin
         mem[a] = 8'hA5;
         mem15[a] = 8'hA5;
      end
      for (int n = 0; n < 64; n++) begin
         mem[1+n] = 8'(img[n]);
         mem15[1+n] = 8'(img[n]);
      end
      for (int n = 0; n < 9; n++) begin
         exp1[n] = model(n / 3, n % 3, 1);
         exp15[n] = model(n / 3, n % 3, 15);
      end
      repeat (2) @(posedge clk);
      release_rst();
      if (abort) begin
         while (cyc < 30) begin
            @(posedge clk);
            #1 cyc++;
         end
         #1 rst = 1'b0;
         active = 1'b0;
         #1;
         check("rst_read", int'(read), 0);
         check("rst_write", int'(write), 0);
         check("rst_addr", int'(addr), 0);
         check("rst_din", int'(din), 0);
         repeat (2) @(posedge clk);
         release_rst();
      end
      while (cyc < 115) begin
         @(posedge clk);
         #1 cyc++;
      end
      active = 1'b0;
      check("nreads", nreads, 64);
      check("nwrites", nwrites, 9);
      for (int n = 0; n < 9; n++) begin
         check("mem_out", int'(mem[65+n]), exp1[n]);
         check("mem15_out", int'(mem15[65+n]), exp15[n]);
      end
      check("mem_above", int'(mem[74]), 'hA5);
   endtask

   initial begin
      for (int n = 0; n < 64; n++) img[n] = 16;
      run(1'b0);
      check("pin_flat_model", exp1[4], 9);
      check("pin_flat_mem", int'(mem[73]), 9);

      for (int n = 0; n < 64; n++) img[n] = n + 1;
      run(1'b0);
      check("pin_ramp_model", exp1[0], 10);
      check("pin_ramp_65", int'(mem[65]), 10);
      check("pin_ramp_73", int'(mem[73]), 30);

      for (int n = 0; n < 64; n++) img[n] = 255;
      run(1'b0);
      check("pin_sat_model", exp15[0], 255);
      check("pin_255", int'(mem[65]), 143);
      check("pin_255_k15", int'(mem15[69]), 255);

      for (int n = 0; n < 64; n++) img[n] = 0;
      img[0] = 255;
      run(1'b0);
      check("pin_hot_65", int'(mem[65]), 15);
      check("pin_hot_66", int'(mem[66]), 0);
      check("pin_hot_73", int'(mem[73]), 0);

      for (int t = 0; t < 3; t++) begin
         for (int n = 0; n < 64; n++) img[n] = int'($urandom_range(0, 255));
         run(1'b0);
      end

      for (int n = 0; n < 64; n++) img[n] = int'($urandom_range(0, 255));
      run(1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
